// File: rtl/decremento_arbiter.sv
// ---------------------------------------------------------------------------
// decremento_arbiter
//
// Two-requester round-robin arbiter feeding a registered decrement unit.
// In IDLE the block grants one of the two operand requesters, takes the
// granted operand on a valid/ready handshake and computes Op - 1. It does
// this as Op + all-ones, which gives the carry-out flag directly. The result
// and its flags are held in DONE until the consumer takes them, so at most
// one result is produced every two cycles.
//
// Ports
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   a_valid_i    requester A has an operand
//   a_data_i     requester A signed operand
//   a_ready_o    A operand accepted this cycle (with a_valid_i)
//   b_valid_i    requester B has an operand
//   b_data_i     requester B signed operand
//   b_ready_o    B operand accepted this cycle (with b_valid_i)
//   res_valid_o  result registers hold a valid result
//   res_ready_i  consumer takes the result this cycle (with res_valid_o)
//   res_data_o   registered Op - 1, two's complement, wraps
//   res_src_o    origin of result: 0 = A, 1 = B
//   res_n_o      negative flag (res_data_o MSB)
//   res_v_o      signed overflow flag
//   res_co_o     carry-out of Op + all-ones
// ---------------------------------------------------------------------------
module decremento_arbiter #(
    parameter int unsigned bits = 4
) (
    input  logic            clk,
    input  logic            rst_n,

    input  logic            a_valid_i,
    input  logic [bits-1:0] a_data_i,
    output logic            a_ready_o,

    input  logic            b_valid_i,
    input  logic [bits-1:0] b_data_i,
    output logic            b_ready_o,

    output logic            res_valid_o,
    input  logic            res_ready_i,
    output logic [bits-1:0] res_data_o,
    output logic            res_src_o,
    output logic            res_n_o,
    output logic            res_v_o,
    output logic            res_co_o
);

    typedef enum logic [0:0] {
        StIdle,
        StDone
    } state_e;

    state_e          state_q, state_d;
    logic            last_src_q, last_src_d;
    logic [bits-1:0] res_data_q, res_data_d;
    logic            res_src_q, res_src_d;
    logic            res_v_q, res_v_d;
    logic            res_co_q, res_co_d;

    // Cleared by reset and set on the first edge after release, so no
    // handshake can complete on the edge that releases reset.
    logic            en_q;

    logic            grant_a;
    logic            grant_b;
    logic            accept_en;
    logic            handshake;
    logic [bits-1:0] op;
    logic [bits:0]   sum;

    // ------------------------------------------------------------------
    // Grant: a lone requester wins. Under contention the one that was
    // not served last wins.
    // ------------------------------------------------------------------
    always_comb begin
        grant_a = a_valid_i && (!b_valid_i || last_src_q);
        grant_b = b_valid_i && (!a_valid_i || !last_src_q);
    end

    always_comb begin
        accept_en = en_q && (state_q == StIdle);
        a_ready_o = accept_en && grant_a;
        b_ready_o = accept_en && grant_b;
        handshake = (a_valid_i && a_ready_o) || (b_valid_i && b_ready_o);
    end

    // ------------------------------------------------------------------
    // Datapath: Op + {bits{1'b1}} on a bits+1 wide adder. The top bit is
    // the carry-out, which is 1 for every Op except zero. Overflow happens
    // only when a negative operand turns non-negative, which is the
    // minimum value wrapping to the maximum.
    // ------------------------------------------------------------------
    always_comb begin
        op  = grant_b ? b_data_i : a_data_i;
        sum = {1'b0, op} + {1'b0, {bits{1'b1}}};
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        last_src_d = last_src_q;
        res_data_d = res_data_q;
        res_src_d  = res_src_q;
        res_v_d    = res_v_q;
        res_co_d   = res_co_q;

        unique case (state_q)
            StIdle: begin
                if (handshake) begin
                    res_data_d = sum[bits-1:0];
                    res_co_d   = sum[bits];
                    res_v_d    = op[bits-1] && !sum[bits-1];
                    res_src_d  = grant_b;
                    last_src_d = grant_b;
                    state_d    = StDone;
                end
            end
            StDone: begin
                if (res_ready_i) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            last_src_q <= 1'b1;
            en_q       <= 1'b0;
            res_data_q <= '0;
            res_src_q  <= 1'b0;
            res_v_q    <= 1'b0;
            res_co_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_src_q <= last_src_d;
            en_q       <= 1'b1;
            res_data_q <= res_data_d;
            res_src_q  <= res_src_d;
            res_v_q    <= res_v_d;
            res_co_q   <= res_co_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    always_comb begin
        res_valid_o = (state_q == StDone);
        res_data_o  = res_data_q;
        res_src_o   = res_src_q;
        res_n_o     = res_data_q[bits-1];
        res_v_o     = res_v_q;
        res_co_o    = res_co_q;
    end

endmodule

// File: doc/decremento_arbiter.md
DECREMENTO_ARBITER -- requirements
Module: decremento_arbiter

Interface
REQ-001 Parameter: bits, default 4, operand/result width.
REQ-002 clk  in  1  system clock, all state updates on rising edge.
REQ-003 rst_n  in  1  asynchronous reset, active-low.
REQ-004 a_valid  in  1  requester A has an operand.
REQ-005 a_data  in  bits  requester A signed operand.
REQ-006 a_ready  out  1  A operand accepted this cycle when high with a_valid.
REQ-007 b_valid  in  1  requester B has an operand.
REQ-008 b_data  in  bits  requester B signed operand.
REQ-009 b_ready  out  1  B operand accepted this cycle when high with b_valid.
REQ-010 res_valid  out  1  result registers hold a valid result.
REQ-011 res_ready  in  1  consumer takes result this cycle when high with res_valid.
REQ-012 res_data  out  bits  registered Op-1 (two's complement, wraps).
REQ-013 res_src  out  1  origin of result: 0=A, 1=B.
REQ-014 res_n  out  1  negative flag, = res_data[bits-1].
REQ-015 res_v  out  1  signed overflow flag.
REQ-016 res_co  out  1  carry-out of Op + all-ones.

Function
REQ-017 Two states: IDLE (accepting), DONE (holding result); a 1-bit round-robin pointer last_src records the last granted requester.
REQ-018 IDLE grant: only A valid -> A; only B valid -> B; both valid -> the requester != last_src; neither -> no grant.
REQ-019 a_ready = IDLE and grant is A; b_ready = IDLE and grant is B; never both high; both low in DONE.
REQ-020 Handshake (valid and ready) in IDLE: the clock edge captures the result of the granted operand, sets res_src, updates last_src, and enters DONE.
REQ-021 Arithmetic on a bits+1 wide sum S = Op + {bits{1'b1}}: res_data = S[bits-1:0]; res_co = S[bits] (1 iff Op != 0); res_n = S[bits-1]; res_v = 1 iff Op = 100..0 (result 011..1).
REQ-022 Latency: result visible with res_valid=1 on the cycle after the handshake.
REQ-023 In DONE, res_valid=1 and all res_* outputs stay constant until res_valid and res_ready are both high; that edge returns to IDLE and clears res_valid.
REQ-024 No operand is accepted in the cycle a result drains; maximum throughput is one result per 2 cycles.
REQ-025 A requester dropping valid before ready is not an error; the grant re-evaluates every IDLE cycle.
REQ-026 res_ready while res_valid=0 has no effect.

Reset
REQ-027 rst_n low asynchronously forces: state IDLE, last_src=1 (A wins first contention), res_valid=0, res_data=0, res_src=0, res_n=0, res_v=0, res_co=0.
REQ-028 a_ready and b_ready are 0 while rst_n is low.
REQ-029 Reset asserted in DONE discards the held result; no handshake completes on the edge that releases reset.

Verification
REQ-030 A only, a_data=0101, res_ready=1 -> next cycle res_valid=1, res_data=0100, res_src=0, n=0 v=0 co=1.
REQ-031 B only, b_data=0000 -> res_data=1111, res_src=1, n=1 v=0 co=0.
REQ-032 A only, a_data=1000 -> res_data=0111, n=0 v=1 co=1.
REQ-033 Both valid every cycle, res_ready=1, starting from reset -> grants alternate A,B,A,B; results every 2nd cycle.
REQ-034 Result pending with res_ready=0 for 3 cycles, both requesters valid -> res_* stable, a_ready=b_ready=0; on res_ready=1 -> return to IDLE, then grant to the requester not last served.
REQ-035 rst_n pulsed low in DONE -> res_valid=0 immediately; after release, with both valid, first grant goes to A.
